// File: rtl/sram_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_seq_pkg
// Description : Shared types and constants for the conv-buffer SRAM
//               sequencer: FSM state encoding and SRAM beat sizes in bytes.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int RD_BEAT_BYTES = 16;
    localparam int WR_BEAT_BYTES = 8;

endpackage : sram_seq_pkg
`default_nettype wire

// File: rtl/sram_seq_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : sram_seq_fifo2
// Description : Two-entry FIFO for SRAM read beats. Push and pop may occur
//               in the same cycle; the head entry is presented directly.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               push_i, data_i  - write one entry
//               pop_i           - consume the head entry
//               occ_o           - current number of entries (0..2)
//               head_o          - head entry data
// Revision    : 1.0 - initial release
// ============================================================================
module sram_seq_fifo2 #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [1:0]       occ_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wptr_q;
    logic             rptr_q;
    logic [1:0]       occ_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= ~wptr_q;
            end
            if (pop_i) begin
                rptr_q <= ~rptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[rptr_q];

endmodule : sram_seq_fifo2
`default_nettype wire

// File: rtl/sram_seq.sv
`default_nettype none
// ============================================================================
// Module      : sram_seq
// Description : Conv-buffer SRAM sequencer. One start pulse streams the input
//               region out over rd_valid/rd_ready and commits result beats
//               arriving on wr_valid/wr_ready into the output region.
// Ports       : clk, rst               - clock, async active-high reset
//               start, busy, done      - tile control / status
//               re, addr_r, dout       - SRAM read port (1-cycle latency)
//               we, addr_w, din        - SRAM write port
//               rd_data/valid/ready    - read stream to datapath
//               wr_data/valid/ready    - write stream from datapath
//               chksum                 - XOR of committed write bytes
// Config      : SRAM_SEQ_CHKSUM_EN enables the chksum port and accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_seq
    import sram_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int RD_BASE    = 0,
    parameter int RD_BEATS   = 24,
    parameter int WR_BASE    = 384,
    parameter int WR_BEATS   = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic                                re,
    output logic [ADDR_WIDTH-1:0]               addr_r,
    input  logic [RD_BEAT_BYTES*DATA_WIDTH-1:0] dout,
    output logic                                we,
    output logic [ADDR_WIDTH-1:0]               addr_w,
    output logic [WR_BEAT_BYTES*DATA_WIDTH-1:0] din,
    output logic [RD_BEAT_BYTES*DATA_WIDTH-1:0] rd_data,
    output logic                                rd_valid,
    input  logic                                rd_ready,
    input  logic [WR_BEAT_BYTES*DATA_WIDTH-1:0] wr_data,
    input  logic                                wr_valid,
`ifdef SRAM_SEQ_CHKSUM_EN
    output logic [DATA_WIDTH-1:0]               chksum,
`endif
    output logic                                wr_ready
);

    localparam int RCW = $clog2(RD_BEATS + 1);
    localparam int WCW = $clog2(WR_BEATS + 1);
    localparam logic [RCW-1:0] C_RD_BEATS = RCW'(RD_BEATS);
    localparam logic [WCW-1:0] C_WR_BEATS = WCW'(WR_BEATS);

    state_e                             state_q, state_d;
    logic [RCW-1:0]                     icnt_q, rcnt_q;
    logic [WCW-1:0]                     wcnt_q;
    logic                               inflight_q;
    logic                               we_q;
    logic [ADDR_WIDTH-1:0]              addr_w_q;
    logic [WR_BEAT_BYTES*DATA_WIDTH-1:0] din_q;

    logic       run;
    logic       tile_start;
    logic       pop;
    logic       wr_hs;
    logic [1:0] occ;
    logic [2:0] pending;

    assign run        = (state_q == ST_RUN);
    assign tile_start = (state_q == ST_IDLE) && start;

    // Beats that will occupy the FIFO after this cycle, before any new issue.
    // A read is issued only if its data is guaranteed a free FIFO slot.
    assign pop     = rd_valid && rd_ready;
    assign pending = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

    assign re     = run && (icnt_q < C_RD_BEATS) && (pending < 3'd2);
    assign addr_r = ADDR_WIDTH'(RD_BASE) + (ADDR_WIDTH'(icnt_q) << $clog2(RD_BEAT_BYTES));

    assign wr_ready = run && (wcnt_q < C_WR_BEATS);
    assign wr_hs    = wr_valid && wr_ready;

    assign rd_valid = (occ != 2'd0);
    assign we       = we_q;
    assign addr_w   = addr_w_q;
    assign din      = din_q;

    sram_seq_fifo2 #(
        .WIDTH (RD_BEAT_BYTES*DATA_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (inflight_q),
        .data_i (dout),
        .pop_i  (pop),
        .occ_o  (occ),
        .head_o (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if ((rcnt_q == C_RD_BEATS) && (wcnt_q == C_WR_BEATS) &&
                    (occ == 2'd0) && !inflight_q && !we_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icnt_q     <= '0;
            rcnt_q     <= '0;
            wcnt_q     <= '0;
            inflight_q <= 1'b0;
            we_q       <= 1'b0;
            addr_w_q   <= '0;
            din_q      <= '0;
        end else begin
            inflight_q <= re;
            we_q       <= wr_hs;
            if (tile_start) begin
                icnt_q <= '0;
                rcnt_q <= '0;
                wcnt_q <= '0;
            end else begin
                if (re) begin
                    icnt_q <= icnt_q + RCW'(1);
                end
                if (pop) begin
                    rcnt_q <= rcnt_q + RCW'(1);
                end
                if (wr_hs) begin
                    wcnt_q   <= wcnt_q + WCW'(1);
                    din_q    <= wr_data;
                    addr_w_q <= ADDR_WIDTH'(WR_BASE) +
                                (ADDR_WIDTH'(wcnt_q) << $clog2(WR_BEAT_BYTES));
                end
            end
        end
    end

`ifdef SRAM_SEQ_CHKSUM_EN
    logic [DATA_WIDTH-1:0] chksum_q;
    logic [DATA_WIDTH-1:0] beat_xor;

    always_comb begin
        beat_xor = '0;
        for (int b = 0; b < WR_BEAT_BYTES; b++) begin
            beat_xor = beat_xor ^ wr_data[b*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Updated on the handshake edge so the new value appears alongside we.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chksum_q <= '0;
        end else if (tile_start) begin
            chksum_q <= '0;
        end else if (wr_hs) begin
            chksum_q <= chksum_q ^ beat_xor;
        end
    end

    assign chksum = chksum_q;
`endif

endmodule : sram_seq
`default_nettype wire

// File: tb/tb_sram_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sram_seq
// Description : Directed self-checking bench for sram_seq with a behavioural
//               512-byte SRAM (registered 16-byte read, 8-byte write).
//               Define SRAM_SEQ_CHKSUM_EN to include the checksum tiles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_seq;

    localparam int AW    = 9;
    localparam int RDB   = 24;
    localparam int WRB   = 16;
    localparam int WBASE = 384;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, re, we, rd_valid, wr_ready;
    logic          rd_ready = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] addr_r, addr_w;
    logic [127:0]  dout = '0;
    logic [127:0]  rd_data;
    logic [63:0]   din;
    logic [63:0]   wr_data = '0;
`ifdef SRAM_SEQ_CHKSUM_EN
    logic [7:0]    chksum;
`endif

    sram_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .re       (re),
        .addr_r   (addr_r),
        .dout     (dout),
        .we       (we),
        .addr_w   (addr_w),
        .din      (din),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
`ifdef SRAM_SEQ_CHKSUM_EN
        .chksum   (chksum),
`endif
        .wr_ready (wr_ready)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM; preload fills byte i with i & 0xFF.
    logic [7:0] mem [512];
    logic       preload = 1'b1;
    int         we_total = 0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'(i & 255);
        end else begin
            if (re) for (int b = 0; b < 16; b++) dout[8*b +: 8] <= mem[(int'(addr_r) + b) % 512];
            if (we) begin
                for (int b = 0; b < 8; b++) mem[(int'(addr_w) + b) % 512] <= din[8*b +: 8];
                we_total <= we_total + 1;
            end
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    int wmode = 0;

    function automatic logic [63:0] wbeat(input int k);
        case (wmode)
            1:       return {8{8'hA5}};
            2:       return (k == 0) ? 64'h0102030405060708 : 64'h0;
            default: return 64'h0101010101010101 * 64'(k + 1);
        endcase
    endfunction

    int n_iss, n_pop, n_wr, n_we, n_done, done_cyc, first_v, last_v, last_we;
    int re_viol, stab_err, addr_err, we_err, busy_err;

    // rdpat 0: rd_ready always high; 1: high one cycle in three.
    // wstall: hold wr_valid low until all read beats are popped.
    // abort_at > 0: assert rst once that many read beats are popped.
    task automatic run_tile(input int rdpat, input bit wstall, input int abort_at);
        logic [127:0] exp_rd, held;
        bit           held_v, pop;
        int           wtot;
        n_iss = 0; n_pop = 0; n_wr = 0; n_we = 0; n_done = 0;
        done_cyc = -1; first_v = -1; last_v = -1; last_we = -1;
        re_viol = 0; stab_err = 0; addr_err = 0; we_err = 0; busy_err = 0;
        held_v = 1'b0; held = '0;
        @(posedge clk); #1;
        start = 1'b1; rd_ready = 1'b0; wr_valid = 1'b0;
        for (int c = 1; c <= 160; c++) begin
            @(posedge clk); #1;
            start    = (c == 5);
            rd_ready = (rdpat == 0) ? 1'b1 : (c % 3 == 0);
            wr_valid = wstall ? (n_pop == RDB) : 1'b1;
            wr_data  = wbeat(n_wr);
            #1;
            if (c == 1) begin
                check("busy_cycle1", busy, 1);
                check("re_cycle1", re, 1);
                check("addr_r_first", addr_r, 0);
`ifdef SRAM_SEQ_CHKSUM_EN
                check("chksum_cleared", chksum, 0);
`endif
            end
            pop = rd_valid && rd_ready;
            if (held_v && (!rd_valid || rd_data !== held)) stab_err++;
            held_v = rd_valid && !rd_ready;
            held   = rd_data;
            if (re) begin
                if (n_iss - n_pop - int'(pop) + 1 > 2) re_viol++;
                if (addr_r !== AW'(16 * n_iss)) addr_err++;
                n_iss++;
            end
            if (rd_valid) begin
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            if (pop) begin
                for (int b = 0; b < 16; b++) exp_rd[8*b +: 8] = 8'((16 * n_pop + b) & 255);
                check($sformatf("rd_beat%0d", n_pop), rd_data, exp_rd);
                n_pop++;
            end
            if (wr_valid && wr_ready) n_wr++;
            if (we) begin
                if (addr_w !== AW'(WBASE + 8 * n_we) || din !== wbeat(n_we)) we_err++;
                n_we++;
                last_we = c;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
                if (busy) busy_err++;
            end
            if (abort_at > 0 && n_pop == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_ctrl", {busy, done, re, we, rd_valid, wr_ready}, 0);
                check("abort_addr", {addr_r, addr_w}, 0);
                check("abort_din", din, 0);
                check("abort_rd_data", rd_data, 0);
                wtot = we_total;
                repeat (4) @(posedge clk);
                #1;
                check("abort_no_write", we_total, wtot);
                rst = 1'b0; start = 1'b0; rd_ready = 1'b0; wr_valid = 1'b0;
                return;
            end
            if (done_cyc > 0 && c >= done_cyc + 3) break;
        end
        start = 1'b0; rd_ready = 1'b0; wr_valid = 1'b0;
        check("done_seen", done_cyc > 0, 1);
        check("done_once", n_done, 1);
        check("reads_issued", n_iss, RDB);
        check("reads_popped", n_pop, RDB);
        check("writes_committed", n_we, WRB);
        check("re_overissue", re_viol, 0);
        check("rd_stable", stab_err, 0);
        check("addr_r_seq", addr_err, 0);
        check("we_addr_data", we_err, 0);
        check("busy_at_done", busy_err, 0);
    endtask

    initial begin
        logic [63:0] got64;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", {busy, done, re, we, rd_valid, wr_ready}, 0);
        check("rst_addr", {addr_r, addr_w}, 0);
        check("rst_din", din, 0);
`ifdef SRAM_SEQ_CHKSUM_EN
        check("rst_chksum", chksum, 0);
`endif
        preload = 1'b0;
        rst     = 1'b0;

        // Basic tile with reads and writes both streaming every cycle.
        wmode = 0;
        run_tile(0, 1'b0, 0);
        check("t0_first_valid", first_v, 3);
        check("t0_last_valid", last_v, RDB + 2);
        check("t0_done_cycle", done_cyc, 28);
        for (int k = 0; k < WRB; k++) begin
            for (int b = 0; b < 8; b++) got64[8*b +: 8] = mem[WBASE + 8*k + b];
            check($sformatf("sram_out%0d", k), got64, wbeat(k));
        end
`ifdef SRAM_SEQ_CHKSUM_EN
        check("chksum_basic", chksum, 0);
`endif

        // Read backpressure.
        run_tile(1, 1'b0, 0);

        // Writes held off until the read stream completes.
        run_tile(0, 1'b1, 0);
        check("stall_last_we", last_we, 43);
        check("stall_done_after_we", done_cyc, last_we + 2);

        // Reset mid-tile, then replay from the start of the input region.
        run_tile(0, 1'b0, 10);
        run_tile(0, 1'b0, 0);
        check("replay_done_cycle", done_cyc, 28);

`ifdef SRAM_SEQ_CHKSUM_EN
        wmode = 1;
        run_tile(0, 1'b0, 0);
        check("chksum_a5", chksum, 8'h00);
        wmode = 2;
        run_tile(0, 1'b0, 0);
        check("chksum_0102", chksum, 8'h08);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_sram_seq
`default_nettype wire
